secure_read_decoder: RTL and testbench
======================================

// Module: secure_read_decoder
// PURPOSE
//  Sequential decoder for words stored by the key-gated security path.
//  For protected addresses (> ADDR_THRESH), the write side stores E = ((x-3)^2 + 9) * 3.
//  This block recovers x from E using an iterative divide-by-3, then an exact integer sqrt.
//  Sits between memory read data and the register file; valid/ready on both sides.
// PARAMETERS
//  DATA_W       32       data word width
//  ADDR_W       10       read address width
//  KEY          16'h0032 access key required to read
//  ADDR_THRESH  128      addresses strictly above this are encoded
// PORTS
//  clk           in   1       single clock, rising edge
//  rst_n         in   1       asynchronous active-low reset
//  in_valid      in   1       request valid
//  in_ready      out  1       high only in IDLE
//  data_in_mem   in   DATA_W  encoded (or plain) memory word
//  key_access    in   16      access key
//  read_address  in   ADDR_W  address of word
//  out_valid     out  1       result valid, held until out_ready
//  out_ready     in   1       consumer accepts result
//  data_out_reg  out  DATA_W  decoded word (0 on err/denied)
//  err           out  1       E is not a legal encoding
//  denied        out  1       key mismatch
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid/err/denied=0; data_out_reg=0.
//  Reset mid-operation aborts the transaction silently; no partial output is produced.
//  Accept: in_valid & in_ready at edge 0. Inputs are captured; later input changes are ignored.
//  States: IDLE -> {DONE | DIV} ; DIV(32 cyc) -> CHK(1) -> {DONE | SQRT(16) -> FIX(1) -> DONE}.
//  IDLE decisions:
//   - key != KEY: denied=1, data=0, go to DONE. out_valid in cycle 1.
//   - key ok and addr <= ADDR_THRESH: bypass, data=E, go to DONE. out_valid in cycle 1.
//   - otherwise: go to DIV.
//  DIV: restoring radix-2 divide of E by 3, 1 bit/cycle, MSB first. Yields q and rem.
//  CHK:
//   - rem != 0 or q < 9: err=1, data=0, go to DONE. out_valid in cycle 34.
//   - otherwise: s = q - 9 (32-bit), go to SQRT.
//  SQRT: digit-by-digit isqrt of s, 2 bits/cycle. Yields 16-bit root r and remainder.
//  FIX:
//   - sqrt remainder != 0: err=1, data=0.
//   - otherwise: data = r + 3, zero-extended.
//   - go to DONE. out_valid in cycle 51.
//  DONE: out_valid=1; outputs are stable until out_ready.
//   - out_valid & out_ready: return to IDLE, clear out_valid/err/denied.
//   - A new request is accepted no earlier than the cycle after handshake (no bypass overlap).
//  Arithmetic: unsigned throughout; no wrap in decode.
//   - Roots are nonnegative, so x<3 encodings decode to 6-x (documented ambiguity).
//   - Encoder-wrapped words (|x-3| >= 37838) decode to err or an alias value; not detected.
//  Flags err and denied are mutually exclusive. Bypass data is never checked.
// STRUCTURE
//  Package sec_pkg holds:
//   - KEY_MEM=16'h0032 and ADDR_THRESH=128
//   - state enum {IDLE,DIV,CHK,SQRT,FIX,DONE}
//   - DIV_CYC=32 and SQRT_CYC=16
//  Sub-module sec_isqrt32: start/done iterative sqrt (32-bit in; 16-bit root plus exact flag).
//  Top-level holds the FSM, the divide-by-3 datapath and the cycle counter.
// TESTING
//  1. key=0x0032, addr=0x100, E=0x000BDC36 -> data=0x00000200, err=0, out_valid in cycle 51.
//  2. key=0x0032, addr=0x100, E=0x1B -> data=0x3. E=0x1E -> data=0x4. Both latency 51.
//  3. key=0x0032, addr=0x100:
//     E=0x1C (rem 1) -> err=1, data=0, cycle 34.
//     E=0x18 (q=8) -> err=1, cycle 34.
//     E=0x21 (s=2, not a square) -> err=1, cycle 51.
//  4. key=0x0032, addr=0x080 (=threshold), E=0xDEADBEEF -> bypass: data=0xDEADBEEF, cycle 1.
//     key=0x1234 -> denied=1, data=0, cycle 1.
//  5. Hold out_ready=0 for 10 cycles after case 1: outputs stable and in_ready=0.
//     Release: return to IDLE; a back-to-back request is accepted the next cycle.
//  6. Drop rst_n during SQRT: outputs go to 0 immediately, in_ready=1.
//     After release, a fresh case-1 request decodes correctly.

Source files
------------

// File: rtl/sec_pkg.sv
// Shared constants and state encoding for the secure read decoder.
// Imported by the top-level FSM and the square-root sub-module.
package sec_pkg;

    localparam logic [15:0] KEY_MEM     = 16'h0032;
    localparam int unsigned ADDR_THRESH = 128;
    localparam int unsigned DIV_CYC     = 32;
    localparam int unsigned SQRT_CYC    = 16;

    typedef enum logic [2:0] {
        IDLE,
        DIV,
        CHK,
        SQRT,
        FIX,
        DONE
    } state_e;

endpackage

// File: rtl/sec_isqrt32.sv
// Iterative digit-by-digit integer square root, two radicand bits per cycle.
// Produces a 16-bit floor root and flags whether the radicand was a perfect square.
module sec_isqrt32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [31:0] x_i,
    output logic        done_o,
    output logic [15:0] root_o,
    output logic        exact_o
);
    import sec_pkg::*;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] x_q, x_d;
    logic [17:0] rem_q, rem_d;
    logic [15:0] root_q, root_d;

    logic [19:0] rem_sh;
    logic [19:0] trial;
    logic        ge;

    // Remainder never exceeds 2*root, so 18 bits always suffice.
    assign rem_sh = {rem_q, x_q[31:30]};
    assign trial  = {2'b00, root_q, 2'b01};
    assign ge     = (rem_sh >= trial);

    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        cnt_d  = cnt_q;
        x_d    = x_q;
        rem_d  = rem_q;
        root_d = root_q;
        if (start_i) begin
            busy_d = 1'b1;
            done_d = 1'b0;
            cnt_d  = 4'd0;
            x_d    = x_i;
            rem_d  = 18'd0;
            root_d = 16'd0;
        end else if (busy_q) begin
            x_d    = {x_q[29:0], 2'b00};
            rem_d  = ge ? 18'(rem_sh - trial) : 18'(rem_sh);
            root_d = {root_q[14:0], ge};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'(SQRT_CYC - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= 4'd0;
            x_q    <= 32'd0;
            rem_q  <= 18'd0;
            root_q <= 16'd0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            x_q    <= x_d;
            rem_q  <= rem_d;
            root_q <= root_d;
        end
    end

    assign done_o  = done_q;
    assign root_o  = root_q;
    assign exact_o = (rem_q == 18'd0);

endmodule

// File: rtl/secure_read_decoder.sv
// Recovers x from E = ((x-3)^2 + 9) * 3 for protected reads: divide by 3,
// subtract 9, exact integer sqrt, add 3. Plain reads bypass; bad keys are denied.
import sec_pkg::*;

module secure_read_decoder #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 10,
    parameter logic [15:0] KEY         = sec_pkg::KEY_MEM,
    parameter int unsigned ADDR_THRESH = sec_pkg::ADDR_THRESH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in_mem,
    input  logic [15:0]       key_access,
    input  logic [ADDR_W-1:0] read_address,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out_reg,
    output logic              err,
    output logic              denied
);

    localparam logic [ADDR_W-1:0] THR = ADDR_W'(ADDR_THRESH);

    state_e            st_q, st_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] e_q, e_d;
    logic [1:0]        rem_q, rem_d;
    logic              ov_q, ov_d;
    logic              err_q, err_d;
    logic              den_q, den_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [2:0]  div_t;
    logic        div_ge;
    logic        q_ok;
    logic        sq_start;
    logic [31:0] sq_x;
    logic        sq_done;
    logic [15:0] sq_root;
    logic        sq_exact;
    logic [16:0] fix_val;

    // e_q shifts the dividend out at the top and the quotient in at the bottom.
    assign div_t    = {rem_q, e_q[DATA_W-1]};
    assign div_ge   = (div_t >= 3'd3);
    assign q_ok     = (rem_q == 2'd0) && (e_q >= DATA_W'(9));
    assign sq_x     = 32'(e_q - DATA_W'(9));
    assign sq_start = (st_q == CHK) && q_ok;
    assign fix_val  = {1'b0, sq_root} + 17'd3;

    sec_isqrt32 u_sqrt (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (sq_start),
        .x_i     (sq_x),
        .done_o  (sq_done),
        .root_o  (sq_root),
        .exact_o (sq_exact)
    );

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        e_d    = e_q;
        rem_d  = rem_q;
        ov_d   = ov_q;
        err_d  = err_q;
        den_d  = den_q;
        data_d = data_q;
        unique case (st_q)
            IDLE: begin
                if (in_valid) begin
                    e_d   = data_in_mem;
                    rem_d = 2'd0;
                    cnt_d = 5'd0;
                    if (key_access != KEY) begin
                        den_d  = 1'b1;
                        data_d = '0;
                        ov_d   = 1'b1;
                        st_d   = DONE;
                    end else if (read_address <= THR) begin
                        data_d = data_in_mem;
                        ov_d   = 1'b1;
                        st_d   = DONE;
                    end else begin
                        st_d = DIV;
                    end
                end
            end
            DIV: begin
                e_d   = {e_q[DATA_W-2:0], div_ge};
                rem_d = div_ge ? 2'(div_t - 3'd3) : div_t[1:0];
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(DIV_CYC - 1)) begin
                    st_d = CHK;
                end
            end
            CHK: begin
                cnt_d = 5'd0;
                if (q_ok) begin
                    st_d = SQRT;
                end else begin
                    err_d  = 1'b1;
                    data_d = '0;
                    ov_d   = 1'b1;
                    st_d   = DONE;
                end
            end
            SQRT: begin
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'(SQRT_CYC - 1)) begin
                    st_d = FIX;
                end
            end
            FIX: begin
                if (sq_done && sq_exact) begin
                    data_d = DATA_W'(fix_val);
                end else begin
                    err_d  = 1'b1;
                    data_d = '0;
                end
                ov_d = 1'b1;
                st_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    ov_d   = 1'b0;
                    err_d  = 1'b0;
                    den_d  = 1'b0;
                    data_d = '0;
                    st_d   = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            cnt_q  <= 5'd0;
            e_q    <= '0;
            rem_q  <= 2'd0;
            ov_q   <= 1'b0;
            err_q  <= 1'b0;
            den_q  <= 1'b0;
            data_q <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            e_q    <= e_d;
            rem_q  <= rem_d;
            ov_q   <= ov_d;
            err_q  <= err_d;
            den_q  <= den_d;
            data_q <= data_d;
        end
    end

    assign in_ready     = (st_q == IDLE);
    assign out_valid    = ov_q;
    assign err          = err_q;
    assign denied       = den_q;
    assign data_out_reg = data_q;

endmodule

// File: tb/tb_secure_read_decoder.sv
// Bench for secure_read_decoder: directed cases plus randomized traffic
// checked against an arithmetic model of the decode rules.
module tb_secure_read_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] data_in_mem = '0;
    logic [15:0] key_access = '0;
    logic [9:0]  read_address = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] data_out_reg;
    logic        err;
    logic        denied;

    int errors = 0;
    int checks = 0;

    secure_read_decoder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_in_mem  (data_in_mem),
        .key_access   (key_access),
        .read_address (read_address),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_out_reg (data_out_reg),
        .err          (err),
        .denied       (denied)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint unsigned isqrt(input longint unsigned s);
        longint unsigned lo, hi, mid;
        lo = 0;
        hi = 65536;
        while (lo + 1 < hi) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= s) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    function automatic void model(input logic [15:0] k, input logic [9:0] a,
                                  input logic [31:0] e, output logic [31:0] d,
                                  output logic er, output logic dn,
                                  output int lat);
        longint unsigned q, s, r;
        d  = '0;
        er = 1'b0;
        dn = 1'b0;
        if (k != 16'h0032) begin
            dn  = 1'b1;
            lat = 1;
        end else if (a <= 10'd128) begin
            d   = e;
            lat = 1;
        end else begin
            q = longint'(e) / 3;
            if ((e % 3) != 0 || q < 9) begin
                er  = 1'b1;
                lat = 34;
            end else begin
                s   = q - 9;
                r   = isqrt(s);
                lat = 51;
                if (r * r != s) er = 1'b1;
                else d = 32'(r + 3);
            end
        end
    endfunction

    // Per-cycle monitor: held results must not move, flags exclusive.
    logic        pv, pr, pe, pdn;
    logic [31:0] pd;
    always @(posedge clk) begin
        pv  = out_valid;
        pr  = out_ready;
        pd  = data_out_reg;
        pe  = err;
        pdn = denied;
        #1;
        if (rst_n && pv && !pr) begin
            checks++;
            if (!(out_valid && data_out_reg === pd && err === pe && denied === pdn)) begin
                errors++;
                $display("FAIL hold_stable: v=%0b d=%0h e=%0b n=%0b want d=%0h e=%0b n=%0b",
                         out_valid, data_out_reg, err, denied, pd, pe, pdn);
            end
        end
        if (out_valid === 1'b1) begin
            checks++;
            if ((err && denied) || ((err || denied) && data_out_reg != 0) || in_ready) begin
                errors++;
                $display("FAIL valid_flags: e=%0b n=%0b d=%0h rdy=%0b required exclusive flags, zero data, rdy=0",
                         err, denied, data_out_reg, in_ready);
            end
        end
    end

    task automatic run(input logic [15:0] k, input logic [9:0] a,
                       input logic [31:0] e, input int hold, input bit pin,
                       input logic [31:0] pdat, input logic perr,
                       input int plat);
        logic [31:0] md;
        logic        me, mn;
        int          ml, lat;
        model(k, a, e, md, me, mn, ml);
        if (pin) begin
            chk("pin_data", md, pdat);
            chk("pin_err", 32'(me), 32'(perr));
            chk("pin_lat", ml, plat);
        end
        key_access   = k;
        read_address = a;
        data_in_mem  = e;
        in_valid     = 1'b1;
        chk("in_ready_idle", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid     = 1'b0;
        data_in_mem  = $urandom;
        key_access   = 16'($urandom);
        read_address = 10'($urandom);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, ml);
        chk("data", data_out_reg, md);
        chk("err", 32'(err), 32'(me));
        chk("denied", 32'(denied), 32'(mn));
        repeat (hold) begin
            @(posedge clk);
            #1;
            chk("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("release_valid", 32'(out_valid), 0);
        chk("release_ready", 32'(in_ready), 1);
        chk("release_err", 32'(err | denied), 0);
    endtask

    initial begin
        logic [31:0] x, dx, e;
        logic [15:0] k;
        logic [9:0]  a;
        int          sel;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_flags", 32'(err | denied), 0);
        chk("rst_data", data_out_reg, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(16'h0032, 10'h100, 32'h000BDC36, 0, 1, 32'h200, 1'b0, 51);
        run(16'h0032, 10'h100, 32'h1B, 0, 1, 32'h3, 1'b0, 51);
        run(16'h0032, 10'h100, 32'h1E, 0, 1, 32'h4, 1'b0, 51);
        run(16'h0032, 10'h100, 32'h1C, 0, 1, 32'h0, 1'b1, 34);
        run(16'h0032, 10'h100, 32'h18, 0, 1, 32'h0, 1'b1, 34);
        run(16'h0032, 10'h100, 32'h21, 0, 1, 32'h0, 1'b1, 51);
        run(16'h0032, 10'h080, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 1'b0, 1);
        run(16'h1234, 10'h100, 32'h000BDC36, 0, 1, 32'h0, 1'b0, 1);
        run(16'h0032, 10'h081, 32'h1B, 0, 1, 32'h3, 1'b0, 51);

        run(16'h0032, 10'h100, 32'h000BDC36, 10, 1, 32'h200, 1'b0, 51);
        run(16'h0032, 10'h100, 32'h1B, 0, 1, 32'h3, 1'b0, 51);

        key_access   = 16'h0032;
        read_address = 10'h100;
        data_in_mem  = 32'h000BDC36;
        in_valid     = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_ready", 32'(in_ready), 1);
        chk("midrst_flags", 32'(err | denied), 0);
        chk("midrst_data", data_out_reg, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(16'h0032, 10'h100, 32'h000BDC36, 0, 1, 32'h200, 1'b0, 51);

        for (int i = 0; i < 40; i++) begin
            x   = $urandom_range(0, 70000);
            dx  = x - 32'd3;
            e   = (dx * dx + 32'd9) * 32'd3;
            k   = 16'h0032;
            a   = 10'($urandom_range(129, 1023));
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                k = 16'($urandom);
                if (k == 16'h0032) k = 16'h0033;
            end else if (sel == 1) begin
                a = 10'($urandom_range(0, 128));
            end else if (sel == 2) begin
                e = $urandom;
            end else if (sel == 3) begin
                e = e + 32'($urandom_range(1, 2));
            end
            run(k, a, e, $urandom_range(0, 3), 0, 32'h0, 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
